// File: rtl/wb_data_select.sv
// Registered write-back data selector: picks a datapath source or built-in constant,
// stages it, and releases it to the register file as a one-cycle write pulse on commit.
module wb_data_select #(
    parameter int DATA_W    = 32,
    parameter int N_SRC     = 6,
    parameter int SEL_W     = 4,
    parameter int VEC_CONST = 227
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_SRC*DATA_W-1:0] src_bus,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    shl_half,
    input  logic                    cap,
    input  logic                    commit,
    output logic                    hold_valid,
    output logic [DATA_W-1:0]       hold_data,
    output logic                    wr_en,
    output logic [DATA_W-1:0]       wr_data,
    output logic                    err,
    output logic                    dbg_state
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [DATA_W-1:0] VEC_VAL = DATA_W'(VEC_CONST);
    localparam int                HALF    = DATA_W / 2;

    state_t              state_q;
    logic [DATA_W-1:0]   hold_q;
    logic                wr_en_q;
    logic [DATA_W-1:0]   wr_data_q;
    logic                err_q;

    logic                sel_legal;
    logic [DATA_W-1:0]   sel_value;
    logic [DATA_W-1:0]   cap_value_d;
    logic                commit_ok;

    // Source/constant decode; anything above the vector constant is illegal.
    always_comb begin
        sel_legal = 1'b0;
        sel_value = '0;
        for (int k = 0; k < N_SRC; k++) begin
            if (sel == SEL_W'(k)) begin
                sel_legal = 1'b1;
                sel_value = src_bus[k*DATA_W +: DATA_W];
            end
        end
        if (sel == SEL_W'(N_SRC)) begin
            sel_legal = 1'b1;
            sel_value = '0;
        end else if (sel == SEL_W'(N_SRC + 1)) begin
            sel_legal = 1'b1;
            sel_value = DATA_W'(1);
        end else if (sel == SEL_W'(N_SRC + 2)) begin
            sel_legal = 1'b1;
            sel_value = VEC_VAL;
        end
    end

    always_comb begin
        cap_value_d = shl_half ? (sel_value << HALF) : sel_value;
        commit_ok   = commit && (state_q == HOLD);
    end

    // Write pulse always drains the value held before this edge, so cap+commit
    // in one cycle writes the old value while latching the new one.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            hold_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            wr_en_q <= commit_ok;
            if (commit_ok) begin
                wr_data_q <= hold_q;
            end
            if (cap && !sel_legal) begin
                err_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (cap && sel_legal) begin
                        hold_q  <= cap_value_d;
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (cap && sel_legal) begin
                        hold_q <= cap_value_d;
                    end else if (commit) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign hold_valid = (state_q == HOLD);
    assign hold_data  = hold_q;
    assign wr_en      = wr_en_q;
    assign wr_data    = wr_data_q;
    assign err        = err_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_wb_data_select.sv
// Bench for wb_data_select: directed cases plus randomized traffic against a
// behavioural model; write pulses are checked by a monitor draining an expected queue.
module tb_wb_data_select;

    localparam int DATA_W = 32;
    localparam int N_SRC  = 6;
    localparam int SEL_W  = 4;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [N_SRC*DATA_W-1:0] src_bus;
    logic [SEL_W-1:0]        sel;
    logic                    shl_half;
    logic                    cap;
    logic                    commit;
    logic                    hold_valid;
    logic [DATA_W-1:0]       hold_data;
    logic                    wr_en;
    logic [DATA_W-1:0]       wr_data;
    logic                    err;
    logic                    dbg_state;

    logic [DATA_W-1:0] src [N_SRC];

    always_comb begin
        src_bus = '0;
        for (int k = 0; k < N_SRC; k++) src_bus[k*DATA_W +: DATA_W] = src[k];
    end

    wb_data_select #(.DATA_W(DATA_W), .N_SRC(N_SRC), .SEL_W(SEL_W), .VEC_CONST(227)) dut (
        .clk(clk), .reset(reset), .src_bus(src_bus), .sel(sel), .shl_half(shl_half),
        .cap(cap), .commit(commit), .hold_valid(hold_valid), .hold_data(hold_data),
        .wr_en(wr_en), .wr_data(wr_data), .err(err), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] exp_q[$];

    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_err;
    logic              m_wr_en;
    logic [DATA_W-1:0] m_wr;

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic ref_legal(input int s);
        return s <= N_SRC + 2;
    endfunction

    function automatic logic [DATA_W-1:0] ref_value(input int s, input logic sh);
        longint v;
        if (s < N_SRC)            v = longint'(src[s]);
        else if (s == N_SRC)      v = 0;
        else if (s == N_SRC + 1)  v = 1;
        else                      v = 227 % (longint'(1) << DATA_W);
        if (sh) v = v * (longint'(1) << (DATA_W / 2));
        return DATA_W'(v % (longint'(1) << DATA_W));
    endfunction

    // One clock cycle: drive inputs, advance the model, then compare registered outputs.
    task automatic step(input logic c, input int s, input logic sh, input logic cm, input logic r);
        logic nxt_valid;
        cap = c; sel = SEL_W'(s); shl_half = sh; commit = cm; reset = r;
        if (r) begin
            m_valid = 0; m_data = '0; m_err = 0; m_wr_en = 0; m_wr = '0;
        end else begin
            m_wr_en   = cm && m_valid;
            nxt_valid = m_wr_en ? 1'b0 : m_valid;
            if (m_wr_en) begin
                m_wr = m_data;
                exp_q.push_back(m_data);
            end
            if (c && ref_legal(s)) begin
                m_data    = ref_value(s, sh);
                nxt_valid = 1'b1;
            end else if (c) begin
                m_err = 1'b1;
            end
            m_valid = nxt_valid;
        end
        @(posedge clk);
        #1;
        check("hold_valid", DATA_W'(hold_valid), DATA_W'(m_valid));
        check("hold_data", hold_data, m_data);
        check("err", DATA_W'(err), DATA_W'(m_err));
        check("wr_en", DATA_W'(wr_en), DATA_W'(m_wr_en));
        check("wr_data", wr_data, m_wr);
        check("dbg_state", DATA_W'(dbg_state), DATA_W'(m_valid));
    endtask

    // Monitor: every write pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wr_pulse: unexpected write 0x%08h at %0t", wr_data, $time);
            end else begin
                check("wr_pulse", wr_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        for (int k = 0; k < N_SRC; k++) src[k] = '0;
        cap = 0; sel = '0; shl_half = 0; commit = 0; reset = 1;
        m_valid = 0; m_data = '0; m_err = 0; m_wr_en = 0; m_wr = '0;

        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);

        // Basic capture and commit
        src[0] = 32'h0000_1234;
        step(1, 0, 0, 0, 0);
        src[0] = 32'hDEAD_BEEF;
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);

        // Constants and half shift
        step(1, 6, 0, 0, 0); step(0, 0, 0, 1, 0);
        step(1, 7, 0, 0, 0); step(0, 0, 0, 1, 0);
        step(1, 8, 0, 0, 0); step(0, 0, 0, 1, 0);
        step(1, 7, 1, 0, 0); step(0, 0, 0, 1, 0);
        src[1] = 32'h0000_ABCD;
        step(1, 1, 1, 0, 0); step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);

        // Back-to-back writeback
        src[2] = 32'hA; src[3] = 32'hB;
        step(1, 2, 0, 0, 0);
        step(1, 3, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);

        // Illegal select is sticky and leaves the held value alone
        src[4] = 32'h55;
        step(1, 4, 0, 0, 0);
        step(1, 9, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        step(1, 15, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        // Commit in idle, last capture wins
        step(0, 0, 0, 1, 0);
        src[0] = 32'h1; src[5] = 32'h2;
        step(1, 0, 0, 0, 0);
        step(1, 5, 0, 0, 0);
        step(0, 0, 0, 1, 0);

        // Reset coinciding with commit discards the held value
        src[0] = 32'h77;
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0);

        // Illegal cap together with commit still commits
        src[2] = 32'h99;
        step(1, 2, 0, 0, 0);
        step(1, 12, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < N_SRC; k++) src[k] = $urandom;
            step(logic'($urandom_range(0, 1)),
                 ($urandom_range(0, 9) == 0) ? int'($urandom_range(9, 15)) : int'($urandom_range(0, 8)),
                 logic'($urandom_range(0, 1)),
                 logic'($urandom_range(0, 1)),
                 logic'($urandom_range(0, 49) == 0));
        end
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        check("exp_q_drained", DATA_W'(exp_q.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
